load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT, default 16, max REQ-state cycles without ack before abort; legal range 2..255.
REQ-002 clk_i  input  1  single clock; all state changes on rising edge.
REQ-003 rst_i_l  input  1  synchronous active-low reset, sampled on rising edge of clk_i.
REQ-004 mem_rd_w_i_h  input  1  load request from control decode.
REQ-005 mem_wr_w_i_h  input  1  store request from control decode.
REQ-006 funct3_w_i  input  3  access size/sign: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; stores use 000/001/010 only.
REQ-007 addr_w_i  input  32  byte address from ALU.
REQ-008 wdata_w_i  input  32  store data (rs2).
REQ-009 rdata_w_o  output  32  extended load result, valid only in DONE.
REQ-010 stall_w_o_h  output  1  holds pipeline while access is pending.
REQ-011 err_w_o_h  output  1  one-cycle pulse: misaligned, illegal funct3, rd+wr together, or timeout.
REQ-012 dmem_req_w_o_h  output  1  memory request, held until ack.
REQ-013 dmem_we_w_o_h  output  1  1 = write, 0 = read.
REQ-014 dmem_addr_w_o  output  32  word address, {addr[31:2], 2'b00}.
REQ-015 dmem_be_w_o  output  4  byte enables.
REQ-016 dmem_wdata_w_o  output  32  lane-replicated store data.
REQ-017 dmem_rdata_w_i  input  32  read word, valid with ack.
REQ-018 dmem_ack_w_i_h  input  1  memory completion, single-cycle pulse.

Function
REQ-019 FSM states IDLE, REQ, DONE, ERR.
REQ-020 IDLE, rd or wr high: stall_w_o_h = 1 combinationally in the same cycle.
REQ-021 IDLE, legal request: capture addr, wdata, funct3 and direction; go to REQ.
REQ-022 IDLE, illegal request: go to ERR; no dmem request issued.
REQ-023 Illegal request: rd and wr both high; any funct3 outside REQ-006; halfword with addr[0]=1; word with addr[1:0]!=00.
REQ-024 REQ: dmem_req_w_o_h = 1; dmem_addr/be/wdata/we driven from captured values and held stable; stall_w_o_h = 1.
REQ-025 REQ, dmem_ack_w_i_h = 1: register extended load data (loads only); go to DONE.
REQ-026 REQ, no ack: increment cycle counter; when counter reaches TIMEOUT-1 without ack, drop the request and go to ERR.
REQ-027 DONE: stall_w_o_h = 0; rdata_w_o valid (0 for stores); ignore core inputs; go to IDLE next cycle.
REQ-028 ERR: stall_w_o_h = 0; err_w_o_h = 1; rdata_w_o = 0; go to IDLE next cycle.
REQ-029 Minimum latency with ack on the first REQ cycle: stall high 2 cycles (IDLE, REQ), DONE on the 3rd cycle.
REQ-030 Byte enables: byte = 4'b0001 << addr[1:0]; half = 0011 (addr[1]=0) or 1100 (addr[1]=1); word = 1111.
REQ-031 Store data: byte replicated x4; half replicated x2; word passed through.
REQ-032 Load extraction: select the byte/half addressed by addr[1:0] from dmem_rdata_w_i.
REQ-033 Load extension: lb/lh sign-extend to 32 bits; lbu/lhu zero-extend; lw passed through.
REQ-034 Ack arriving outside REQ is ignored.
REQ-035 Outside REQ: dmem_req_w_o_h, dmem_we_w_o_h and dmem_be_w_o = 0.

Reset
REQ-036 rst_i_l = 0 at a clock edge forces IDLE, counter 0, rdata 0 and captured registers 0, regardless of state.
REQ-037 Reset during REQ: the request drops the following cycle; a later ack is ignored.
REQ-038 All outputs are 0 while in reset.

Verification
REQ-039 lw addr 0x100, ack on first REQ cycle, rdata 0xDEADBEEF -> stall high 2 cycles, rdata_w_o = 0xDEADBEEF in DONE, be = 1111.
REQ-040 lb addr 0x103, rdata 0x80FFFFFF -> rdata_w_o = 0xFFFFFF80; lbu same access -> 0x00000080.
REQ-041 sh addr 0x22, wdata 0x1234ABCD -> be = 1100, dmem_wdata = 0xABCDABCD, we = 1, dmem_addr = 0x20.
REQ-042 lw addr 0x101 -> err pulse 1 cycle, no dmem_req, stall high exactly 1 cycle.
REQ-043 Ack withheld, TIMEOUT = 16 -> req held 16 cycles then dropped, err pulse; a later ack is ignored.
REQ-044 Reset asserted during REQ -> req = 0 the next cycle, FSM in IDLE, all outputs 0.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: turns one decoded load or store into a single data-memory
// request, with byte/half lane steering, load extension and an ack timeout.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i_l,
  input  logic        mem_rd_w_i_h,
  input  logic        mem_wr_w_i_h,
  input  logic [2:0]  funct3_w_i,
  input  logic [31:0] addr_w_i,
  input  logic [31:0] wdata_w_i,
  output logic [31:0] rdata_w_o,
  output logic        stall_w_o_h,
  output logic        err_w_o_h,
  output logic        dmem_req_w_o_h,
  output logic        dmem_we_w_o_h,
  output logic [31:0] dmem_addr_w_o,
  output logic [3:0]  dmem_be_w_o,
  output logic [31:0] dmem_wdata_w_o,
  input  logic [31:0] dmem_rdata_w_i,
  input  logic        dmem_ack_w_i_h,
  output logic [1:0]  state_dbg_o
);
  // dmem handshake: dmem_req is held with stable addr/be/wdata/we until a
  // single-cycle dmem_ack; the access completes on the cycle ack is seen.
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_ERR} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        we_q, we_d;
  logic [31:0] rdata_q, rdata_d;

  logic        f3_ok, misaligned, illegal;
  logic [31:0] lane;
  logic [31:0] load_ext;

  always_comb begin
    f3_ok = 1'b0;
    case (funct3_w_i)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      3'b100, 3'b101:         f3_ok = mem_rd_w_i_h;
      default:                f3_ok = 1'b0;
    endcase
  end

  assign misaligned = ((funct3_w_i[1:0] == 2'b01) && addr_w_i[0]) ||
                      ((funct3_w_i[1:0] == 2'b10) && (addr_w_i[1:0] != 2'b00));
  assign illegal    = (mem_rd_w_i_h && mem_wr_w_i_h) || !f3_ok || misaligned;

  // Shift the addressed lane down to bit 0 before extension.
  assign lane = dmem_rdata_w_i >> {addr_q[1:0], 3'b000};

  always_comb begin
    load_ext = dmem_rdata_w_i;
    case (funct3_q)
      3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_ext = {24'd0, lane[7:0]};
      3'b101:  load_ext = {16'd0, lane[15:0]};
      default: load_ext = dmem_rdata_w_i;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    funct3_d = funct3_q;
    we_d     = we_q;
    rdata_d  = rdata_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = 8'd0;
        if (mem_rd_w_i_h || mem_wr_w_i_h) begin
          if (illegal) begin
            state_d = S_ERR;
          end else begin
            addr_d   = addr_w_i;
            wdata_d  = wdata_w_i;
            funct3_d = funct3_w_i;
            we_d     = mem_wr_w_i_h;
            state_d  = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (dmem_ack_w_i_h) begin
          rdata_d = we_q ? 32'd0 : load_ext;
          cnt_d   = 8'd0;
          state_d = S_DONE;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          cnt_d   = 8'd0;
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i_l) begin
      state_q  <= S_IDLE;
      cnt_q    <= 8'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      funct3_q <= 3'd0;
      we_q     <= 1'b0;
      rdata_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      funct3_q <= funct3_d;
      we_q     <= we_d;
      rdata_q  <= rdata_d;
    end
  end

  logic in_req;
  assign in_req = (state_q == S_REQ);

  always_comb begin
    dmem_be_w_o    = 4'b0000;
    dmem_wdata_w_o = 32'd0;
    if (in_req) begin
      case (funct3_q[1:0])
        2'b00: begin
          dmem_be_w_o    = 4'b0001 << addr_q[1:0];
          dmem_wdata_w_o = {4{wdata_q[7:0]}};
        end
        2'b01: begin
          dmem_be_w_o    = addr_q[1] ? 4'b1100 : 4'b0011;
          dmem_wdata_w_o = {2{wdata_q[15:0]}};
        end
        default: begin
          dmem_be_w_o    = 4'b1111;
          dmem_wdata_w_o = wdata_q;
        end
      endcase
    end
  end

  // Stall is combinational in IDLE so the pipeline freezes on the request cycle.
  assign stall_w_o_h    = rst_i_l && (in_req ||
                          ((state_q == S_IDLE) && (mem_rd_w_i_h || mem_wr_w_i_h)));
  assign err_w_o_h      = (state_q == S_ERR);
  assign rdata_w_o      = (state_q == S_DONE) ? rdata_q : 32'd0;
  assign dmem_req_w_o_h = in_req;
  assign dmem_we_w_o_h  = in_req && we_q;
  assign dmem_addr_w_o  = in_req ? {addr_q[31:2], 2'b00} : 32'd0;
  assign state_dbg_o    = state_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed corner accesses plus random ones,
// checked cycle by cycle against an arithmetic model of the access rules.
module tb_load_store_unit;
  localparam int unsigned TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        rd, wr;
  logic [2:0]  f3;
  logic [31:0] addr, wdata;
  logic [31:0] rdata_o;
  logic        stall, err, req, we;
  logic [31:0] maddr;
  logic [3:0]  be;
  logic [31:0] mwdata, mrdata;
  logic        ack;
  logic [1:0]  st;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  load_store_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_i_l(rst_l),
    .mem_rd_w_i_h(rd), .mem_wr_w_i_h(wr), .funct3_w_i(f3),
    .addr_w_i(addr), .wdata_w_i(wdata), .rdata_w_o(rdata_o),
    .stall_w_o_h(stall), .err_w_o_h(err),
    .dmem_req_w_o_h(req), .dmem_we_w_o_h(we), .dmem_addr_w_o(maddr),
    .dmem_be_w_o(be), .dmem_wdata_w_o(mwdata),
    .dmem_rdata_w_i(mrdata), .dmem_ack_w_i_h(ack), .state_dbg_o(st)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // ---- reference model: access size in bytes drives everything ----
  function automatic int size_of(input logic [2:0] fn);
    return 1 << int'(fn[1:0]);
  endfunction

  function automatic bit m_legal(input bit r, input bit w, input logic [2:0] fn, input logic [31:0] a);
    if (r && w) return 0;
    if (w && fn > 3'd2) return 0;
    if (!(fn inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 0;
    return (a % size_of(fn)) == 0;
  endfunction

  function automatic logic [31:0] m_be(input logic [2:0] fn, input logic [31:0] a);
    int unsigned v;
    v = ((32'd1 << size_of(fn)) - 1) << (a % 4);
    return v;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] fn, input logic [31:0] d);
    if (size_of(fn) == 1) return (d & 32'hFF) * 32'h01010101;
    if (size_of(fn) == 2) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] word);
    logic [31:0] v, mask;
    int n;
    n = 8 * size_of(fn);
    if (n == 32) return word;
    v = word >> (8 * (a % 4));
    mask = (32'd1 << n) - 1;
    v = v & mask;
    if (fn < 3'd4 && v[n-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic idle_inputs();
    rd = 0; wr = 0; f3 = 0; addr = 0; wdata = 0; ack = 0; mrdata = 0;
  endtask

  // One access; delay < 0 withholds ack so the timeout path is taken.
  task automatic do_txn(input bit r, input bit w, input logic [2:0] fn,
                        input logic [31:0] a, input logic [31:0] d,
                        input int delay, input logic [31:0] mem);
    bit legal;
    legal = m_legal(r, w, fn, a);
    @(negedge clk);
    rd = r; wr = w; f3 = fn; addr = a; wdata = d;
    #1 check("stall_idle", {31'd0, stall}, 1);
    @(negedge clk);
    rd = 0; wr = 0;
    if (!legal) begin
      check("err_pulse", {31'd0, err}, 1);
      check("err_noreq", {31'd0, req}, 0);
      check("err_stall", {31'd0, stall}, 0);
      check("err_rdata", rdata_o, 0);
      @(negedge clk);
      check("err_clear", {31'd0, err}, 0);
      return;
    end
    if (r) exp_q.push_back(m_load(fn, a, mem));
    else   exp_q.push_back(32'd0);
    for (int c = 0; c < int'(TIMEOUT); c++) begin
      check("req", {31'd0, req}, 1);
      check("stall_req", {31'd0, stall}, 1);
      check("we", {31'd0, we}, {31'd0, w});
      check("maddr", maddr, {a[31:2], 2'b00});
      check("be", {28'd0, be}, m_be(fn, a));
      if (w) check("wdata", mwdata, m_wdata(fn, d));
      if (c == delay) begin
        ack = 1; mrdata = mem;
        @(negedge clk);
        ack = 0; mrdata = 32'hA5A5_5A5A;
        check("done_stall", {31'd0, stall}, 0);
        check("done_req", {31'd0, req}, 0);
        check("done_rdata", rdata_o, exp_q.pop_front());
        @(negedge clk);
        check("back_idle", {30'd0, st}, 0);
        return;
      end
      @(negedge clk);
    end
    void'(exp_q.pop_front());
    check("to_err", {31'd0, err}, 1);
    check("to_req_drop", {31'd0, req}, 0);
    ack = 1; mrdata = 32'h1111_2222;
    @(negedge clk);
    ack = 0;
    check("late_ack_err", {31'd0, err}, 0);
    check("late_ack_idle", {30'd0, st}, 0);
    check("late_ack_req", {31'd0, req}, 0);
  endtask

  initial begin
    idle_inputs();
    rst_l = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", {31'd0, stall}, 0);
    check("rst_req", {31'd0, req}, 0);
    check("rst_err", {31'd0, err}, 0);
    check("rst_be", {28'd0, be}, 0);
    check("rst_state", {30'd0, st}, 0);
    rst_l = 1;

    do_txn(1, 0, 3'b010, 32'h100, 0, 0, 32'hDEADBEEF);
    do_txn(1, 0, 3'b000, 32'h103, 0, 0, 32'h80FFFFFF);
    do_txn(1, 0, 3'b100, 32'h103, 0, 2, 32'h80FFFFFF);
    do_txn(0, 1, 3'b001, 32'h22, 32'h1234ABCD, 1, 0);
    do_txn(1, 0, 3'b010, 32'h101, 0, 0, 0);
    do_txn(1, 0, 3'b101, 32'h202, 0, 0, 32'h8001_7FFF);
    do_txn(1, 0, 3'b001, 32'h202, 0, 0, 32'h8001_7FFF);
    do_txn(1, 1, 3'b010, 32'h40, 0, 0, 0);
    do_txn(0, 1, 3'b100, 32'h40, 0, 0, 0);
    do_txn(1, 0, 3'b011, 32'h40, 0, 0, 0);
    do_txn(1, 0, 3'b010, 32'h300, 0, -1, 0);

    // Reset while a request is outstanding; a later ack must be ignored.
    @(negedge clk);
    rd = 1; f3 = 3'b010; addr = 32'h400;
    @(negedge clk);
    rd = 0;
    check("pre_rst_req", {31'd0, req}, 1);
    rst_l = 0;
    @(negedge clk);
    check("rstq_req", {31'd0, req}, 0);
    check("rstq_state", {30'd0, st}, 0);
    check("rstq_stall", {31'd0, stall}, 0);
    check("rstq_addr", maddr, 0);
    rst_l = 1; ack = 1; mrdata = 32'hFFFF_FFFF;
    @(negedge clk);
    ack = 0;
    check("rstq_ack_ign", {30'd0, st}, 0);
    check("rstq_rdata", rdata_o, 0);

    for (int i = 0; i < 60; i++) begin
      int k;
      logic [31:0] a;
      k = $urandom_range(0, 9);
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      do_txn(k == 0 ? 1'b1 : k < 6, k == 0 ? 1'b1 : k >= 6,
             3'($urandom_range(0, 7)), a, $urandom,
             $urandom_range(0, 4), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
